// File: rtl/hssim_stream_ctrl_if.sv
// Stream bundle for the HSSIM flow controller: input edge-map stream and
// result stream. The controller uses the slave view; the producer/consumer
// environment uses the master view.
interface hssim_stream_ctrl_if #(
    parameter int DATA_WIDTH = 128,
    parameter int DEL_WIDTH  = 128
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_last;
    logic [DATA_WIDTH-1:0] s_old_map;
    logic [DATA_WIDTH-1:0] s_avg_map;
    logic [DATA_WIDTH-1:0] s_new_map;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [DEL_WIDTH-1:0]  m_data;

    modport slave (
        input  s_valid, s_last, s_old_map, s_avg_map, s_new_map, m_ready,
        output s_ready, m_valid, m_last, m_data
    );

    modport master (
        output s_valid, s_last, s_old_map, s_avg_map, s_new_map, m_ready,
        input  s_ready, m_valid, m_last, m_data
    );
endinterface

// File: rtl/hssim_stream_ctrl.sv
// Flow controller for the HSSIM fusion datapath. Accepted beats are tagged
// through a shadow shift register that advances in lockstep with the
// fixed-latency datapath, so output valid/last line up with pipe_del.
// After the last beat of a frame, zero bubbles are pushed to drain results.
module hssim_stream_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT,
    parameter int PIPE_LATENCY    = 72,
    parameter int BEATS_PER_FRAME = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    hssim_stream_ctrl_if.slave           strm,
    output logic [DATA_WIDTH-1:0]        pipe_old_map,
    output logic [DATA_WIDTH-1:0]        pipe_avg_map,
    output logic [DATA_WIDTH-1:0]        pipe_new_map,
    output logic                         stall,
    input  logic [8*PIXELS_PER_BEAT-1:0] pipe_del,
    output logic                         frame_done,
    output logic                         last_err
);
    localparam int CNT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state;
    logic [PIPE_LATENCY-1:0] tag;
    logic [PIPE_LATENCY-1:0] lst;
    logic [CNT_W-1:0]        cnt;
    logic                    taken;

    logic cnt_end;
    logic blocked;
    logic ready;
    logic accept;
    logic adv;
    logic valid;
    logic last;
    logic out_hs;

    assign cnt_end = (cnt == CNT_LAST);
    assign valid   = tag[PIPE_LATENCY-1] & ~taken;
    assign last    = valid & lst[PIPE_LATENCY-1];
    assign blocked = valid & ~strm.m_ready;
    assign ready   = (state == RUN) & ~blocked;
    assign accept  = strm.s_valid & ready;
    // A result handshake alone never advances the pipe; only accepts and
    // flush bubbles do, and only when the output is not blocked.
    assign adv     = ~blocked & (accept | (state == FLUSH));
    assign out_hs  = valid & strm.m_ready;

    assign stall        = ~adv;
    assign strm.s_ready = ready;
    assign strm.m_valid = valid;
    assign strm.m_last  = last;
    assign strm.m_data  = pipe_del;

    // Datapath inputs carry the accepted beat, otherwise a zero bubble.
    always_comb begin
        pipe_old_map = '0;
        pipe_avg_map = '0;
        pipe_new_map = '0;
        if (accept) begin
            pipe_old_map = strm.s_old_map;
            pipe_avg_map = strm.s_avg_map;
            pipe_new_map = strm.s_new_map;
        end
    end

    // FSM, shadow tag/last shift registers, beat counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tag        <= '0;
            lst        <= '0;
            cnt        <= '0;
            taken      <= 1'b0;
            frame_done <= 1'b0;
            last_err   <= 1'b0;
        end else begin
            frame_done <= out_hs & last;

            if (adv) begin
                tag[0] <= accept;
                lst[0] <= accept & cnt_end;
                for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
                    tag[i] <= tag[i-1];
                    lst[i] <= lst[i-1];
                end
            end

            // Once consumed while the pipe is idle, the head result must
            // not be presented again until the pipe moves.
            if (adv) begin
                taken <= 1'b0;
            end else if (out_hs) begin
                taken <= 1'b1;
            end

            if (accept) begin
                cnt <= cnt_end ? '0 : cnt + CNT_W'(1);
                if (strm.s_last != cnt_end) begin
                    last_err <= 1'b1;
                end
            end

            case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (accept && cnt_end) state <= FLUSH;
                FLUSH:   if (out_hs && last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hssim_stream_ctrl.sv
// Bench for hssim_stream_ctrl: a behavioural fixed-latency datapath model,
// a scoreboard fed on input accepts and drained on output handshakes.
module tb_hssim_stream_ctrl;
    localparam int PPB = 4;
    localparam int DIM = 8;
    localparam int DW  = 8*PPB;
    localparam int PL  = 5;
    localparam int BPF = DIM*DIM/PPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] pipe_old_map;
    logic [DW-1:0] pipe_avg_map;
    logic [DW-1:0] pipe_new_map;
    logic          stall;
    logic [DW-1:0] pipe_del;
    logic          frame_done;
    logic          last_err;

    hssim_stream_ctrl_if #(.DATA_WIDTH(DW), .DEL_WIDTH(DW)) strm ();

    hssim_stream_ctrl #(
        .PIXELS_PER_BEAT(PPB),
        .IMAGE_DIM(DIM),
        .DATA_WIDTH(DW),
        .PIPE_LATENCY(PL),
        .BEATS_PER_FRAME(BPF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .strm(strm.slave),
        .pipe_old_map(pipe_old_map),
        .pipe_avg_map(pipe_avg_map),
        .pipe_new_map(pipe_new_map),
        .stall(stall),
        .pipe_del(pipe_del),
        .frame_done(frame_done),
        .last_err(last_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the HSSIM datapath: PL-stage pipe advancing when stall=0.
    function automatic logic [DW-1:0] hssim_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
        return (a ^ {b[DW-9:0], b[DW-1:DW-8]}) + c;
    endfunction

    logic [DW-1:0] dp [PL] = '{default: '0};
    always @(posedge clk) begin
        if (!stall) begin
            dp[0] <= hssim_fn(pipe_old_map, pipe_avg_map, pipe_new_map);
            for (int i = 1; i < PL; i++) dp[i] <= dp[i-1];
        end
    end
    assign pipe_del = dp[PL-1];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    exp_t item;
    exp_t got_item;
    int   in_idx = 0;
    int   out_idx = 0;
    int   out_count = 0;
    int   done_count = 0;
    int   adv_count = 0;
    int   cyc = 0;
    int   acc0_cyc = 0;
    int   val0_cyc = 0;
    logic [DW-1:0] hold_data;

    // Monitor on the falling edge: handshakes seen here complete at the next rise.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            sb.delete();
            in_idx  = 0;
            out_idx = 0;
        end else begin
            if (strm.s_valid && strm.s_ready) begin
                if (in_idx == 0) acc0_cyc = cyc;
                item.data = hssim_fn(strm.s_old_map, strm.s_avg_map, strm.s_new_map);
                item.last = (in_idx == BPF-1);
                sb.push_back(item);
                in_idx = (in_idx == BPF-1) ? 0 : in_idx + 1;
            end
            if (!stall && !(strm.m_valid && strm.m_ready && strm.m_last)) adv_count++;
            if (strm.m_valid && strm.m_ready) begin
                if (out_idx == 0) val0_cyc = cyc;
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    got_item = sb.pop_front();
                    check("m_data", strm.m_data, got_item.data);
                    check("m_last", strm.m_last, got_item.last);
                end
                out_count++;
                out_idx = (out_idx == BPF-1) ? 0 : out_idx + 1;
            end
            if (frame_done) begin
                done_count++;
                check("done_idle_sready", strm.s_ready, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic last_flag);
        strm.s_valid   = 1'b1;
        strm.s_last    = last_flag;
        strm.s_old_map = $urandom;
        strm.s_avg_map = $urandom;
        strm.s_new_map = $urandom;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (strm.s_ready) begin
                tick();
                strm.s_valid = 1'b0;
                strm.s_last  = 1'b0;
                return;
            end
        end
        check("accept_timeout", 0, 1);
        tick();
        strm.s_valid = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input bit gap, input int bad_idx, input int hold);
        for (int k = 0; k < nbeats; k++) begin
            send_beat((k == bad_idx) || (k == BPF-1));
            if (gap && k < nbeats-1) begin
                @(negedge clk);
                check("gap_stall", stall, 1);
                tick();
            end
        end
        if (hold > 0) begin
            strm.s_valid   = 1'b1;
            strm.s_old_map = $urandom;
            strm.s_avg_map = $urandom;
            strm.s_new_map = $urandom;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("flush_sready", strm.s_ready, 0);
                check("flush_bubble", pipe_old_map | pipe_avg_map | pipe_new_map, 0);
                tick();
            end
            strm.s_valid = 1'b0;
        end
    endtask

    task automatic start_frame();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 400; t++) begin
            if (done_count >= target) return;
            @(negedge clk);
        end
        check("done_timeout", done_count, target);
    endtask

    initial begin
        strm.s_valid   = 1'b0;
        strm.s_last    = 1'b0;
        strm.s_old_map = '0;
        strm.s_avg_map = '0;
        strm.s_new_map = '0;
        strm.m_ready   = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_s_ready", strm.s_ready, 0);
        check("rst_m_valid", strm.m_valid, 0);
        check("rst_m_last", strm.m_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_last_err", last_err, 0);
        check("rst_stall", stall, 1);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("idle_s_ready", strm.s_ready, 0);
        tick();

        // Full-rate frame followed by held s_valid during flush.
        strm.m_ready = 1'b1;
        out_count = 0;
        adv_count = 0;
        start_frame();
        send_frame(BPF, 1'b0, -1, 4);
        wait_done(1);
        check("f1_out_count", out_count, BPF);
        check("f1_adv_count", adv_count, BPF + PL - 1);
        check("f1_latency", val0_cyc - acc0_cyc, PL);
        tick();

        // Output backpressure when the first result appears.
        strm.m_ready = 1'b0;
        out_count = 0;
        start_frame();
        fork
            send_frame(BPF, 1'b0, -1, 0);
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 300 && !seen; t++) begin
                    @(negedge clk);
                    if (strm.m_valid) seen = 1'b1;
                end
                if (!seen) check("bp_timeout", 0, 1);
                check("bp_stall", stall, 1);
                check("bp_s_ready", strm.s_ready, 0);
                hold_data = strm.m_data;
                repeat (3) @(negedge clk);
                check("bp_hold_data", strm.m_data, hold_data);
                check("bp_hold_valid", strm.m_valid, 1);
                @(posedge clk);
                #1;
                strm.m_ready = 1'b1;
            end
        join
        wait_done(2);
        check("f2_out_count", out_count, BPF);
        tick();

        // Input gaps: idle clocks between beats exercise the taken flag.
        out_count = 0;
        start_frame();
        send_frame(BPF, 1'b1, -1, 0);
        wait_done(3);
        check("f3_out_count", out_count, BPF);
        check("f3_last_err", last_err, 0);
        tick();

        // Early s_last on beat 10.
        out_count = 0;
        start_frame();
        send_frame(BPF, 1'b0, 9, 0);
        wait_done(4);
        check("f4_out_count", out_count, BPF);
        check("f4_last_err", last_err, 1);
        repeat (3) tick();
        check("f4_last_err_sticky", last_err, 1);

        // Reset after 7 beats, then a clean frame.
        start_frame();
        send_frame(7, 1'b0, -1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", strm.m_valid, 0);
        check("mid_rst_last_err", last_err, 0);
        check("mid_rst_s_ready", strm.s_ready, 0);
        tick();
        out_count = 0;
        start_frame();
        send_frame(BPF, 1'b0, -1, 0);
        wait_done(5);
        check("f5_out_count", out_count, BPF);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
